seven_seg_scan_driver: RTL

Parametrised successor to the team's 4-digit binary-to-seven-segment display driver. Latches a binary value on a load strobe and converts it to BCD with a sequential double-dabble engine. Time-multiplexes NUM_DIGITS common-anode digits with anti-ghosting blanking, leading-zero suppression, a decimal point, an overflow indication and a display-off mode. Sits between the datapath (step count, distance) and the board's anode/segment pins.

---
 rtl/seven_seg_pkg.sv | 31 +++
 rtl/bin_to_bcd_seq.sv | 74 +++++++
 rtl/seven_seg_scan_driver.sv | 127 ++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared encodings and the segment decoder for the multiplexed seven-segment driver.
package seven_seg_pkg;

    localparam logic [1:0] MODE_INT_BLANK = 2'b00;
    localparam logic [1:0] MODE_INT_FULL  = 2'b01;
    localparam logic [1:0] MODE_FIXED_DP  = 2'b10;
    localparam logic [1:0] MODE_OFF       = 2'b11;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle, BIN_WIDTH steps.
module bin_to_bcd_seq #(
    parameter int BIN_WIDTH  = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_WIDTH-1:0]      bin,
    output logic                      busy,
    output logic                      done,
    output logic [4*NUM_DIGITS-1:0]   bcd,
    output logic                      overflow
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SR_W  = BCD_W + BIN_WIDTH;
    localparam int CNT_W = $clog2(BIN_WIDTH);
    localparam logic [BIN_WIDTH-1:0] MAX_VAL = BIN_WIDTH'(10 ** NUM_DIGITS - 1);

    logic [SR_W-1:0]  sr_q, sr_d, sr_adj, sr_next;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             last_step;

    assign last_step = busy_q && (cnt_q == CNT_W'(BIN_WIDTH - 1));

    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sr_adj[BIN_WIDTH+4*i +: 4] >= 4'd5)
                sr_adj[BIN_WIDTH+4*i +: 4] = sr_adj[BIN_WIDTH+4*i +: 4] + 4'd3;
        end
        sr_next = {sr_adj[SR_W-2:0], 1'b0};

        sr_d   = sr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        ovf_d  = ovf_q;
        if (busy_q) begin
            sr_d  = sr_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step)
                busy_d = 1'b0;
        end else if (start) begin
            sr_d   = SR_W'(bin);
            cnt_d  = '0;
            busy_d = 1'b1;
            ovf_d  = (bin > MAX_VAL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            ovf_q  <= ovf_d;
        end
    end

    // done/bcd are combinational so the caller can latch the result on the same edge BUSY falls.
    assign busy     = busy_q;
    assign done     = last_step;
    assign bcd      = sr_next[SR_W-1:BIN_WIDTH];
    assign overflow = ovf_q;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode display driver with blanking, zero suppression and overflow dashes.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BIN_WIDTH    = 14,
    parameter int REFRESH_DIV  = 2000,
    parameter int BLANK_CYCLES = 8,
    parameter int DP_POS       = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  LOAD,
    input  logic [BIN_WIDTH-1:0]  BIN_IN,
    input  logic [1:0]            MODE,
    output logic                  BUSY,
    output logic [NUM_DIGITS-1:0] ANODE,
    output logic [6:0]            SEG,
    output logic                  DP
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PRE_W-1:0]                presc_q, presc_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [1:0]                      mode_q, mode_d;
    logic [NUM_DIGITS-1:0][3:0]      digit_q, digit_d;
    logic                            ovf_q, ovf_d;
    logic [NUM_DIGITS-1:0]           anode_q, anode_d;
    logic [6:0]                      seg_q, seg_d;
    logic                            dp_q, dp_d;

    logic                            conv_done;
    logic                            conv_ovf;
    logic [4*NUM_DIGITS-1:0]         conv_bcd;
    logic [NUM_DIGITS-1:0]           lz;
    logic                            upper_zero;
    logic                            blank;

    bin_to_bcd_seq #(
        .BIN_WIDTH  (BIN_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk      (CLK),
        .rst_n    (RESET),
        .start    (LOAD),
        .bin      (BIN_IN),
        .busy     (BUSY),
        .done     (conv_done),
        .bcd      (conv_bcd),
        .overflow (conv_ovf)
    );

    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        idx_d   = idx_q;
        mode_d  = mode_q;
        // MODE is sampled once per slot so a slot never mixes two display styles.
        if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            mode_d  = MODE;
        end

        digit_d = digit_q;
        ovf_d   = ovf_q;
        if (conv_done) begin
            digit_d = conv_bcd;
            ovf_d   = conv_ovf;
        end

        // lz[i]: digit i and every digit above it are zero.
        upper_zero = 1'b1;
        lz         = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (digit_d[i] == 4'd0);
            lz[i]      = upper_zero;
        end

        case (mode_d)
            MODE_INT_BLANK: blank = lz[idx_d] && (idx_d != '0);
            MODE_FIXED_DP:  blank = lz[idx_d] && (idx_d > IDX_W'(DP_POS));
            default:        blank = 1'b0;
        endcase

        if (ovf_d)
            seg_d = SEG_DASH;
        else if (blank)
            seg_d = SEG_BLANK;
        else
            seg_d = bcd_to_seg(digit_d[idx_d]);

        dp_d = !((mode_d == MODE_FIXED_DP) && (idx_d == IDX_W'(DP_POS)) && !ovf_d);

        anode_d = '1;
        if ((presc_d >= PRE_W'(BLANK_CYCLES)) && (mode_d != MODE_OFF))
            anode_d[idx_d] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            presc_q <= '0;
            idx_q   <= '0;
            mode_q  <= MODE_INT_BLANK;
            digit_q <= '0;
            ovf_q   <= 1'b0;
            anode_q <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            digit_q <= digit_d;
            ovf_q   <= ovf_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign ANODE = anode_q;
    assign SEG   = seg_q;
    assign DP    = dp_q;

endmodule
